// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bus access arbiter.
// Holds the sequencer state encoding, statistics counter width, legal
// parameter ranges, and a saturating-increment helper for the counters.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } arb_state_t;

   localparam int unsigned STAT_WIDTH  = 16;
   localparam int unsigned DATA_WIDTH  = 32;
   localparam int unsigned MIN_NUM_REQ = 2;
   localparam int unsigned MAX_NUM_REQ = 4;
   localparam int unsigned MIN_RD_LAT  = 1;
   localparam int unsigned MAX_RD_LAT  = 7;
   localparam int unsigned CNT_WIDTH   = 3;

   // Saturating +1 for the statistics counters.
   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (v == '1) ? v : STAT_WIDTH'(v + 1'b1);
   endfunction

endpackage

// File: rtl/reg_access_arb_rr_arb.sv
// Round-robin grant selection for the register-bus arbiter.
// Searches the request vector starting one position after the pointer and
// wrapping around; the first set bit wins.
// Ports:
//   req          in   request vector
//   ptr          in   index of the previous winner
//   grant_c      out  one-hot grant (combinational)
//   grant_idx_c  out  index of the granted requester (combinational)
//   any_c        out  at least one request present (combinational)
module rr_arb #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [IDX_W-1:0]   grant_idx_c,
   output logic               any_c
);

   logic [IDX_W-1:0] idx;

   // Wrapping priority scan, highest priority just after the last winner.
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      any_c       = 1'b0;
      idx         = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
         if (!any_c && req[idx]) begin
            any_c        = 1'b1;
            grant_idx_c  = idx;
            grant_c[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_access_arb.sv
// Round-robin arbiter/sequencer sharing one CPU register bus among NUM_REQ
// requesters. One access in flight: accept -> ACC (address/write strobe) ->
// WAIT (read latency) -> RSP (completion pulse) -> IDLE.
// Optional feature macro: REG_ARB_STAT_EN enables saturating completed
// write/read counters; otherwise stat_wr_cnt/stat_rd_cnt are tied to zero.
// Ports:
//   clks, reset            clock, synchronous active-high reset
//   req_vld/req_wr         per-requester valid and write flag
//   req_addr/req_wdata     per-requester address and write data (packed)
//   req_rdy                one-hot accept (combinational in IDLE)
//   rsp_vld/rsp_rdata      one-hot completion pulse and read data
//   cpu_addr/cpu_wr        shared register-bus address and 1-cycle write strobe
//   cpu_data_in            shared write data; cpu_data_out read data from bank
//   stat_wr_cnt/stat_rd_cnt completed access counters
module reg_access_arb
   import reg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                            clks,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_vld,
   input  logic [NUM_REQ-1:0]              req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]              req_rdy,
   output logic [NUM_REQ-1:0]              rsp_vld,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [ADDR_WIDTH-1:0]           cpu_addr,
   output logic                            cpu_wr,
   output logic [DATA_WIDTH-1:0]           cpu_data_in,
   input  logic [DATA_WIDTH-1:0]           cpu_data_out,
   output logic [STAT_WIDTH-1:0]           stat_wr_cnt,
   output logic [STAT_WIDTH-1:0]           stat_rd_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   // Parameter range guards.
   if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
      $error("reg_access_arb: NUM_REQ must be in 2..4");
   end
   if (RD_LAT < MIN_RD_LAT || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $error("reg_access_arb: RD_LAT must be in 1..7");
   end

   arb_state_t              state, state_nxt;
   logic [IDX_W-1:0]        ptr, ptr_nxt;
   logic [IDX_W-1:0]        cur_idx, idx_nxt;
   logic                    cur_wr, wr_nxt;
   logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [DATA_WIDTH-1:0]   wdata_nxt;
   logic                    cpu_wr_nxt;
   logic [NUM_REQ-1:0]      rsp_vld_nxt;
   logic [DATA_WIDTH-1:0]   rdata_nxt;
   logic                    sample;

   logic [NUM_REQ-1:0]      gnt_oh;
   logic [IDX_W-1:0]        gnt_idx;
   logic                    gnt_any;

   rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
      .req         (req_vld),
      .ptr         (ptr),
      .grant_c     (gnt_oh),
      .grant_idx_c (gnt_idx),
      .any_c       (gnt_any)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      idx_nxt     = cur_idx;
      wr_nxt      = cur_wr;
      cnt_nxt     = cnt;
      addr_nxt    = cpu_addr;
      wdata_nxt   = cpu_data_in;
      cpu_wr_nxt  = 1'b0;
      rsp_vld_nxt = '0;
      rdata_nxt   = rsp_rdata;
      req_rdy     = '0;
      sample      = 1'b0;

      unique case (state)
         IDLE: begin
            // Accept is suppressed while reset is asserted so no transfer is lost.
            if (gnt_any && !reset) begin
               req_rdy    = gnt_oh;
               ptr_nxt    = gnt_idx;
               idx_nxt    = gnt_idx;
               wr_nxt     = req_wr[gnt_idx];
               cpu_wr_nxt = req_wr[gnt_idx];
               addr_nxt   = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_nxt  = req_wdata[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
               state_nxt  = ACC;
            end
         end
         ACC: begin
            if (RD_LAT == 1) begin
               sample = 1'b1;
            end else begin
               // Counts the remaining WAIT cycles after this one.
               cnt_nxt   = CNT_WIDTH'(RD_LAT - 2);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               sample = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RSP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Last bus cycle of the access: capture read data and raise the response.
      if (sample) begin
         state_nxt            = RSP;
         rsp_vld_nxt[cur_idx] = 1'b1;
         rdata_nxt            = cur_wr ? '0 : cpu_data_out;
      end
   end

   // State and output registers.
   always_ff @(posedge clks) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= IDX_W'(NUM_REQ - 1);
         cur_idx     <= '0;
         cur_wr      <= 1'b0;
         cnt         <= '0;
         cpu_addr    <= '0;
         cpu_data_in <= '0;
         cpu_wr      <= 1'b0;
         rsp_vld     <= '0;
         rsp_rdata   <= '0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         cur_idx     <= idx_nxt;
         cur_wr      <= wr_nxt;
         cnt         <= cnt_nxt;
         cpu_addr    <= addr_nxt;
         cpu_data_in <= wdata_nxt;
         cpu_wr      <= cpu_wr_nxt;
         rsp_vld     <= rsp_vld_nxt;
         rsp_rdata   <= rdata_nxt;
      end
   end

`ifdef REG_ARB_STAT_EN
   logic [STAT_WIDTH-1:0] wr_cnt;
   logic [STAT_WIDTH-1:0] rd_cnt;

   // Completed-access counters, bumped once per RSP cycle.
   always_ff @(posedge clks) begin
      if (reset) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else if (state == RSP) begin
         if (cur_wr) begin
            wr_cnt <= sat_inc(wr_cnt);
         end else begin
            rd_cnt <= sat_inc(rd_cnt);
         end
      end
   end

   assign stat_wr_cnt = wr_cnt;
   assign stat_rd_cnt = rd_cnt;
`else
   assign stat_wr_cnt = '0;
   assign stat_rd_cnt = '0;
`endif

endmodule
